// File: rtl/ddr_req_master.sv
// DDR request master: round-robin arbitration between fetch and LSU requesters,
// one transaction in flight, registered DDR request fields and a sticky timeout flag.
module ddr_req_master #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned BURST_W = 512,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_req_valid,
   input  logic [ADDR_W-1:0]  fetch_req_addr,
   output logic               fetch_req_ready,
   output logic               fetch_resp_valid,
   output logic [BURST_W-1:0] fetch_resp_data,
   input  logic               lsu_req_valid,
   input  logic               lsu_req_write,
   input  logic [ADDR_W-1:0]  lsu_req_addr,
   input  logic [63:0]        lsu_req_wdata,
   input  logic [63:0]        lsu_req_wmask,
   output logic               lsu_req_ready,
   output logic               lsu_resp_valid,
   output logic [63:0]        lsu_resp_rdata,
   output logic               ddr_chip_enable,
   output logic               ddr_write_enable,
   output logic               ddr_burst_mode,
   output logic [ADDR_W-1:0]  ddr_address,
   output logic [63:0]        ddr_access_write_mask,
   output logic [63:0]        ddr_access_write_data,
   output logic [63:0]        ddr_l2_burst_write_data,
   input  logic [BURST_W-1:0] ddr_fetch_burst_read_inst,
   input  logic [63:0]        ddr_access_read_data,
   input  logic               ddr_ready,
   output logic               err_timeout
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam int unsigned       CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-6){1'b1}}, 6'b000000};

   state_t               state_q;
   logic                 prefer_lsu_q;
   logic                 src_fetch_q;
   logic [CNT_W-1:0]     timer_q;
   logic [CNT_W-1:0]     timer_d;
   logic                 ce_q;
   logic                 we_q;
   logic                 burst_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [63:0]          wmask_q;
   logic [63:0]          wdata_q;
   logic                 fetch_resp_valid_q;
   logic [BURST_W-1:0]   fetch_resp_data_q;
   logic                 lsu_resp_valid_q;
   logic [63:0]          lsu_resp_rdata_q;
   logic                 err_q;
   logic                 grant_lsu;
   logic                 grant_fetch;

   // Grant is decided from live valids; rst_n gating keeps both readies low during reset.
   always_comb begin
      grant_lsu   = 1'b0;
      grant_fetch = 1'b0;
      if (rst_n && state_q == IDLE) begin
         grant_lsu   = lsu_req_valid && (!fetch_req_valid || prefer_lsu_q);
         grant_fetch = fetch_req_valid && !grant_lsu;
      end
      timer_d = timer_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= IDLE;
         prefer_lsu_q       <= 1'b1;
         src_fetch_q        <= 1'b0;
         timer_q            <= '0;
         ce_q               <= 1'b0;
         we_q               <= 1'b0;
         burst_q            <= 1'b0;
         addr_q             <= '0;
         wmask_q            <= '0;
         wdata_q            <= '0;
         fetch_resp_valid_q <= 1'b0;
         fetch_resp_data_q  <= '0;
         lsu_resp_valid_q   <= 1'b0;
         lsu_resp_rdata_q   <= '0;
         err_q              <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_lsu || grant_fetch) begin
                  state_q      <= ISSUE;
                  prefer_lsu_q <= grant_fetch;
                  src_fetch_q  <= grant_fetch;
                  timer_q      <= '0;
                  ce_q         <= 1'b1;
                  if (grant_fetch) begin
                     burst_q <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= fetch_req_addr & LINE_MASK;
                     wdata_q <= '0;
                     wmask_q <= '0;
                  end else begin
                     burst_q <= 1'b0;
                     we_q    <= lsu_req_write;
                     addr_q  <= lsu_req_addr;
                     wdata_q <= lsu_req_wdata;
                     wmask_q <= lsu_req_wmask;
                  end
               end
            end
            ISSUE: begin
               if (ddr_ready || timer_q == TMO_LAST) begin
                  state_q <= RESP;
                  ce_q    <= 1'b0;
                  if (!ddr_ready) begin
                     err_q <= 1'b1;
                  end
                  // A timed-out transaction still answers its source, with zero data.
                  if (src_fetch_q) begin
                     fetch_resp_valid_q <= 1'b1;
                     fetch_resp_data_q  <= ddr_ready ? ddr_fetch_burst_read_inst : '0;
                  end else begin
                     lsu_resp_valid_q <= 1'b1;
                     lsu_resp_rdata_q <= (ddr_ready && !we_q) ? ddr_access_read_data : '0;
                  end
               end else begin
                  timer_q <= timer_d;
               end
            end
            RESP: begin
               state_q            <= IDLE;
               fetch_resp_valid_q <= 1'b0;
               lsu_resp_valid_q   <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign fetch_req_ready         = grant_fetch;
   assign lsu_req_ready           = grant_lsu;
   assign fetch_resp_valid        = fetch_resp_valid_q;
   assign fetch_resp_data         = fetch_resp_data_q;
   assign lsu_resp_valid          = lsu_resp_valid_q;
   assign lsu_resp_rdata          = lsu_resp_rdata_q;
   assign ddr_chip_enable         = ce_q;
   assign ddr_write_enable        = we_q;
   assign ddr_burst_mode          = burst_q;
   assign ddr_address             = addr_q;
   assign ddr_access_write_mask   = wmask_q;
   assign ddr_access_write_data   = wdata_q;
   assign ddr_l2_burst_write_data = '0;
   assign err_timeout             = err_q;

endmodule

// File: tb/tb_ddr_req_master.sv
// Directed bench for ddr_req_master: fetch/LSU transactions, arbitration, timeout, reset.
module tb_ddr_req_master;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         fetch_req_valid = 1'b0;
   logic [63:0]  fetch_req_addr = '0;
   logic         fetch_req_ready;
   logic         fetch_resp_valid;
   logic [511:0] fetch_resp_data;
   logic         lsu_req_valid = 1'b0;
   logic         lsu_req_write = 1'b0;
   logic [63:0]  lsu_req_addr = '0;
   logic [63:0]  lsu_req_wdata = '0;
   logic [63:0]  lsu_req_wmask = '0;
   logic         lsu_req_ready;
   logic         lsu_resp_valid;
   logic [63:0]  lsu_resp_rdata;
   logic         ddr_chip_enable;
   logic         ddr_write_enable;
   logic         ddr_burst_mode;
   logic [63:0]  ddr_address;
   logic [63:0]  ddr_access_write_mask;
   logic [63:0]  ddr_access_write_data;
   logic [63:0]  ddr_l2_burst_write_data;
   logic [511:0] ddr_fetch_burst_read_inst = '0;
   logic [63:0]  ddr_access_read_data = '0;
   logic         ddr_ready = 1'b0;
   logic         err_timeout;

   int checks = 0;
   int errors = 0;

   localparam logic [511:0] BURST_A5 = {64{8'hA5}};
   localparam logic [511:0] BURST_3C = {64{8'h3C}};

   ddr_req_master #(.ADDR_W(64), .BURST_W(512), .TIMEOUT(16)) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .fetch_req_valid           (fetch_req_valid),
      .fetch_req_addr            (fetch_req_addr),
      .fetch_req_ready           (fetch_req_ready),
      .fetch_resp_valid          (fetch_resp_valid),
      .fetch_resp_data           (fetch_resp_data),
      .lsu_req_valid             (lsu_req_valid),
      .lsu_req_write             (lsu_req_write),
      .lsu_req_addr              (lsu_req_addr),
      .lsu_req_wdata             (lsu_req_wdata),
      .lsu_req_wmask             (lsu_req_wmask),
      .lsu_req_ready             (lsu_req_ready),
      .lsu_resp_valid            (lsu_resp_valid),
      .lsu_resp_rdata            (lsu_resp_rdata),
      .ddr_chip_enable           (ddr_chip_enable),
      .ddr_write_enable          (ddr_write_enable),
      .ddr_burst_mode            (ddr_burst_mode),
      .ddr_address               (ddr_address),
      .ddr_access_write_mask     (ddr_access_write_mask),
      .ddr_access_write_data     (ddr_access_write_data),
      .ddr_l2_burst_write_data   (ddr_l2_burst_write_data),
      .ddr_fetch_burst_read_inst (ddr_fetch_burst_read_inst),
      .ddr_access_read_data      (ddr_access_read_data),
      .ddr_ready                 (ddr_ready),
      .err_timeout               (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      fetch_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (fetch_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", fetch_req_ready, lsu_req_ready); end
      checks++; if (ddr_chip_enable !== 1'b0 || ddr_write_enable !== 1'b0 || ddr_burst_mode !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got ce=%b we=%b burst=%b expected 000", ddr_chip_enable, ddr_write_enable, ddr_burst_mode); end
      checks++; if (ddr_address !== 64'h0 || ddr_access_write_data !== 64'h0 || ddr_access_write_mask !== 64'h0 || ddr_l2_burst_write_data !== 64'h0) begin errors++; $display("FAIL reset_fields: got addr=%h wd=%h wm=%h expected 0", ddr_address, ddr_access_write_data, ddr_access_write_mask); end
      checks++; if (fetch_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_resp: got fv=%b lv=%b err=%b expected 000", fetch_resp_valid, lsu_resp_valid, err_timeout); end
      checks++; if (fetch_resp_data !== 512'h0 || lsu_resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_data: got lsu=%h expected 0", lsu_resp_rdata); end
      fetch_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   // Both requesters held valid with ddr_ready held high: grants must go L, F, L.
   task automatic test_round_robin();
      logic [2:0] gnt_lsu;
      logic [2:0] rsp_lsu;
      int ng = 0;
      int nr = 0;
      bit both = 1'b0;
      gnt_lsu = '0;
      rsp_lsu = '0;
      @(negedge clk);
      fetch_req_valid = 1'b1;
      fetch_req_addr = 64'h0000_0000_0000_1000;
      lsu_req_valid = 1'b1;
      lsu_req_write = 1'b0;
      lsu_req_addr = 64'h0000_0000_0000_0008;
      ddr_ready = 1'b1;
      ddr_fetch_burst_read_inst = BURST_3C;
      ddr_access_read_data = 64'h0000_0000_0000_0077;
      for (int c = 0; c < 40 && nr < 3; c++) begin
         if (ng == 3) begin
            fetch_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
         end
         #1;
         if (fetch_req_ready && lsu_req_ready) both = 1'b1;
         if (ng < 3 && (fetch_req_ready || lsu_req_ready)) begin
            gnt_lsu[ng] = lsu_req_ready;
            ng++;
         end
         if (nr < 3 && (fetch_resp_valid || lsu_resp_valid)) begin
            rsp_lsu[nr] = lsu_resp_valid;
            nr++;
         end
         @(negedge clk);
      end
      ddr_ready = 1'b0;
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_single_grant: got both readies high expected one"); end
      checks++; if (ng != 3 || gnt_lsu !== 3'b101) begin errors++; $display("FAIL rr_grant_order: got n=%0d lsu_bits=%b expected n=3 lsu_bits=101", ng, gnt_lsu); end
      checks++; if (nr != 3 || rsp_lsu !== 3'b101) begin errors++; $display("FAIL rr_resp_order: got n=%0d lsu_bits=%b expected n=3 lsu_bits=101", nr, rsp_lsu); end
      repeat (3) @(negedge clk);
      checks++; if (fetch_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || ddr_chip_enable !== 1'b0) begin errors++; $display("FAIL rr_no_extra: got fv=%b lv=%b ce=%b expected 000", fetch_resp_valid, lsu_resp_valid, ddr_chip_enable); end
   endtask

   task automatic test_fetch_read();
      @(negedge clk);
      fetch_req_valid = 1'b1;
      fetch_req_addr = 64'h0000_0000_1234_567F;
      ddr_fetch_burst_read_inst = BURST_A5;
      #1;
      checks++; if (fetch_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready: got f=%b l=%b expected f=1 l=0", fetch_req_ready, lsu_req_ready); end
      @(negedge clk);
      fetch_req_valid = 1'b0;
      fetch_req_addr = '1;
      checks++; if (ddr_chip_enable !== 1'b1 || ddr_burst_mode !== 1'b1 || ddr_write_enable !== 1'b0) begin errors++; $display("FAIL fetch_ctrl: got ce=%b burst=%b we=%b expected 110", ddr_chip_enable, ddr_burst_mode, ddr_write_enable); end
      checks++; if (ddr_address !== 64'h0000_0000_1234_5640) begin errors++; $display("FAIL fetch_addr: got %h expected 0000000012345640", ddr_address); end
      @(negedge clk);
      checks++; if (ddr_chip_enable !== 1'b1 || ddr_address !== 64'h0000_0000_1234_5640 || fetch_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_hold: got ce=%b addr=%h rv=%b expected 1 ..5640 0", ddr_chip_enable, ddr_address, fetch_resp_valid); end
      @(negedge clk);
      ddr_ready = 1'b1;
      @(negedge clk);
      ddr_ready = 1'b0;
      ddr_fetch_burst_read_inst = '0;
      checks++; if (fetch_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0 || ddr_chip_enable !== 1'b0) begin errors++; $display("FAIL fetch_resp_cycle: got fv=%b lv=%b ce=%b expected 100", fetch_resp_valid, lsu_resp_valid, ddr_chip_enable); end
      checks++; if (fetch_resp_data !== BURST_A5) begin errors++; $display("FAIL fetch_resp_data: got %h expected a5 repeated", fetch_resp_data[63:0]); end
      @(negedge clk);
      checks++; if (fetch_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_resp_one_cycle: got %b expected 0", fetch_resp_valid); end
   endtask

   task automatic test_lsu_write();
      @(negedge clk);
      lsu_req_valid = 1'b1;
      lsu_req_write = 1'b1;
      lsu_req_addr = 64'h80;
      lsu_req_wdata = 64'hDEAD_BEEF;
      lsu_req_wmask = 64'hFF;
      ddr_access_read_data = 64'h1111_2222_3333_4444;
      #1;
      checks++; if (lsu_req_ready !== 1'b1 || fetch_req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready: got l=%b f=%b expected l=1 f=0", lsu_req_ready, fetch_req_ready); end
      @(negedge clk);
      lsu_req_valid = 1'b0;
      lsu_req_write = 1'b0;
      lsu_req_addr = 64'hFFFF;
      lsu_req_wdata = 64'h0;
      lsu_req_wmask = 64'h0;
      checks++; if (ddr_chip_enable !== 1'b1 || ddr_write_enable !== 1'b1 || ddr_burst_mode !== 1'b0) begin errors++; $display("FAIL wr_ctrl: got ce=%b we=%b burst=%b expected 110", ddr_chip_enable, ddr_write_enable, ddr_burst_mode); end
      @(negedge clk);
      checks++; if (ddr_address !== 64'h80 || ddr_access_write_data !== 64'hDEAD_BEEF || ddr_access_write_mask !== 64'hFF || ddr_write_enable !== 1'b1) begin errors++; $display("FAIL wr_hold: got addr=%h wd=%h wm=%h we=%b expected 80 deadbeef ff 1", ddr_address, ddr_access_write_data, ddr_access_write_mask, ddr_write_enable); end
      ddr_ready = 1'b1;
      @(negedge clk);
      ddr_ready = 1'b0;
      checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_rdata !== 64'h0 || fetch_resp_valid !== 1'b0) begin errors++; $display("FAIL wr_resp: got lv=%b rdata=%h fv=%b expected 1 0 0", lsu_resp_valid, lsu_resp_rdata, fetch_resp_valid); end
      @(negedge clk);
   endtask

   // Ready on the first ISSUE cycle, then a second request waiting through RESP.
   task automatic test_lsu_read_back_to_back();
      @(negedge clk);
      lsu_req_valid = 1'b1;
      lsu_req_write = 1'b0;
      lsu_req_addr = 64'h100;
      @(negedge clk);
      lsu_req_valid = 1'b0;
      checks++; if (ddr_chip_enable !== 1'b1 || ddr_write_enable !== 1'b0 || ddr_address !== 64'h100) begin errors++; $display("FAIL rd_issue: got ce=%b we=%b addr=%h expected 1 0 100", ddr_chip_enable, ddr_write_enable, ddr_address); end
      ddr_ready = 1'b1;
      ddr_access_read_data = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      ddr_ready = 1'b0;
      ddr_access_read_data = 64'h0;
      checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rd_resp: got lv=%b rdata=%h expected 1 0123456789abcdef", lsu_resp_valid, lsu_resp_rdata); end
      lsu_req_valid = 1'b1;
      lsu_req_addr = 64'h208;
      #1;
      checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL rd_no_accept_in_resp: got %b expected 0", lsu_req_ready); end
      @(negedge clk);
      #1;
      checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL rd_accept_m_plus_2: got %b expected 1", lsu_req_ready); end
      @(negedge clk);
      lsu_req_valid = 1'b0;
      checks++; if (ddr_chip_enable !== 1'b1 || ddr_address !== 64'h208) begin errors++; $display("FAIL rd_second_issue: got ce=%b addr=%h expected 1 208", ddr_chip_enable, ddr_address); end
      ddr_ready = 1'b1;
      @(negedge clk);
      ddr_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stray_ready();
      @(negedge clk);
      ddr_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++; if (fetch_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || ddr_chip_enable !== 1'b0) begin errors++; $display("FAIL stray_ready: got fv=%b lv=%b ce=%b expected 000", fetch_resp_valid, lsu_resp_valid, ddr_chip_enable); end
      end
      ddr_ready = 1'b0;
      #1;
      lsu_req_valid = 1'b1;
      #1;
      checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL stray_still_idle: got %b expected 1", lsu_req_ready); end
      lsu_req_valid = 1'b0;
   endtask

   task automatic test_timeout();
      int ce_cycles = 0;
      bit early_err = 1'b0;
      @(negedge clk);
      lsu_req_valid = 1'b1;
      lsu_req_write = 1'b0;
      lsu_req_addr = 64'h300;
      ddr_access_read_data = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      lsu_req_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (lsu_resp_valid) break;
         if (ddr_chip_enable) ce_cycles++;
         if (err_timeout) early_err = 1'b1;
         @(negedge clk);
      end
      checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("FAIL tmo_resp_seen: got %b expected 1 within 40 cycles", lsu_resp_valid); end
      checks++; if (ce_cycles != 16 || early_err) begin errors++; $display("FAIL tmo_issue_cycles: got %0d early_err=%b expected 16 0", ce_cycles, early_err); end
      checks++; if (err_timeout !== 1'b1 || lsu_resp_rdata !== 64'h0 || ddr_chip_enable !== 1'b0) begin errors++; $display("FAIL tmo_resp: got err=%b rdata=%h ce=%b expected 1 0 0", err_timeout, lsu_resp_rdata, ddr_chip_enable); end
      @(negedge clk);
      checks++; if (lsu_resp_valid !== 1'b0 || err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_after: got lv=%b err=%b expected 0 1", lsu_resp_valid, err_timeout); end
      fetch_req_valid = 1'b1;
      fetch_req_addr = 64'h40;
      #1;
      checks++; if (fetch_req_ready !== 1'b1) begin errors++; $display("FAIL tmo_next_accept: got %b expected 1", fetch_req_ready); end
      @(negedge clk);
      fetch_req_valid = 1'b0;
      ddr_ready = 1'b1;
      ddr_fetch_burst_read_inst = BURST_3C;
      @(negedge clk);
      ddr_ready = 1'b0;
      checks++; if (fetch_resp_valid !== 1'b1 || fetch_resp_data !== BURST_3C || err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_recover: got fv=%b data=%h err=%b expected 1 3c.. 1", fetch_resp_valid, fetch_resp_data[63:0], err_timeout); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_issue();
      bit late_resp = 1'b0;
      @(negedge clk);
      lsu_req_valid = 1'b1;
      lsu_req_write = 1'b1;
      lsu_req_addr = 64'h500;
      lsu_req_wdata = 64'h55;
      lsu_req_wmask = 64'h0F;
      @(negedge clk);
      lsu_req_valid = 1'b0;
      checks++; if (ddr_chip_enable !== 1'b1) begin errors++; $display("FAIL mid_issue_ce: got %b expected 1", ddr_chip_enable); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ddr_chip_enable !== 1'b0 || ddr_write_enable !== 1'b0 || ddr_address !== 64'h0 || ddr_access_write_data !== 64'h0) begin errors++; $display("FAIL async_reset: got ce=%b we=%b addr=%h wd=%h expected 0", ddr_chip_enable, ddr_write_enable, ddr_address, ddr_access_write_data); end
      checks++; if (err_timeout !== 1'b0 || fetch_resp_data !== 512'h0) begin errors++; $display("FAIL async_reset_err: got err=%b fdata=%h expected 0", err_timeout, fetch_resp_data[63:0]); end
      @(negedge clk);
      rst_n = 1'b1;
      ddr_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (fetch_resp_valid || lsu_resp_valid || ddr_chip_enable) late_resp = 1'b1;
      end
      ddr_ready = 1'b0;
      checks++; if (late_resp) begin errors++; $display("FAIL no_resp_after_reset: got activity expected none"); end
      rst_n = 1'b0;
      #2;
      fetch_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      lsu_req_write = 1'b0;
      lsu_req_addr = 64'h600;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (lsu_req_ready !== 1'b1 || fetch_req_ready !== 1'b0) begin errors++; $display("FAIL reset_tie_lsu: got l=%b f=%b expected l=1 f=0", lsu_req_ready, fetch_req_ready); end
      @(negedge clk);
      fetch_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      checks++; if (ddr_chip_enable !== 1'b1 || ddr_address !== 64'h600) begin errors++; $display("FAIL first_edge_accept: got ce=%b addr=%h expected 1 600", ddr_chip_enable, ddr_address); end
      ddr_ready = 1'b1;
      @(negedge clk);
      ddr_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_fetch_read();
      test_lsu_write();
      test_lsu_read_back_to_back();
      test_stray_ready();
      test_timeout();
      test_reset_mid_issue();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
